hazard_stall_ctrl: RTL

//  Central pipeline sequencer for the 5-stage core. Drives the {flush,stall} code of the
//  IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC stall/redirect controls.

---
 rtl/hazard_stall_ctrl_pkg.sv | 30 +++
 rtl/hazard_stall_ctrl_mem_wait_fsm.sv | 62 ++++++
 rtl/hazard_stall_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall sequencer: the {flush,stall}
// register control code and the state encodings of the fetch and data FSMs.
package hazard_pkg;

  typedef enum logic [1:0] {
    FS_NONE  = 2'b00,
    FS_STALL = 2'b01,
    FS_FLUSH = 2'b10
  } fs_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'b00,
    F_BUSY = 2'b01,
    F_HOLD = 2'b10
  } fetch_state_t;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_BUSY = 1'b1
  } mem_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a decode-stage source is actually read and names the given register.
  function automatic logic src_match(input logic uses, input logic [4:0] src,
                                     input logic [4:0] rd);
    return uses && (src == rd);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_mem_wait_fsm.sv
// Data bus handshake sequencer: holds the request until ack, counts wait
// states and abandons the access after MEM_TIMEOUT-1 waits.
// Outputs are not reset-gated here; the top masks them while in reset.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mem_access,
  input  logic mem_ack,
  output logic mem_req,
  output logic mem_stall,
  output logic mem_err
);

  localparam logic [CNT_WIDTH-1:0] LAST_WAIT = CNT_WIDTH'(MEM_TIMEOUT - 1);

  mem_state_t           state;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic                 timeout;

  // Request, stall and timeout decode; an ack in the same cycle ends the stall at once.
  always_comb begin
    timeout   = (state == M_BUSY) && !mem_ack && (wait_cnt == LAST_WAIT);
    mem_req   = ((state == M_IDLE) && mem_access) || (state == M_BUSY);
    mem_stall = mem_req && !mem_ack && !timeout;
    mem_err   = timeout;
  end

  // Wait-state FSM; a timed-out access returns to idle as if it had been acked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= M_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        M_IDLE: begin
          if (mem_access && !mem_ack) begin
            state    <= M_BUSY;
            wait_cnt <= CNT_WIDTH'(1);
          end
        end
        M_BUSY: begin
          if (mem_ack || timeout) begin
            state    <= M_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state    <= M_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central pipeline sequencer for the 5-stage core: fetch handshake FSM,
// load-use and taken-branch hazard resolution, and the per-register
// {flush,stall} priority mux. The data bus FSM lives in mem_wait_fsm.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] id_rs1_addr,
  input  logic       id_uses_rs1,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_mem_read,
  input  logic       mem_access,
  input  logic       br_taken,
  input  logic       if_ack,
  input  logic       mem_ack,
  output logic       if_req,
  output logic       mem_req,
  output logic       if_hold,
  output logic       pc_stall,
  output logic       pc_redirect,
  output logic       mem_err,
  output logic [1:0] if_id_fs,
  output logic [1:0] id_ex_fs,
  output logic [1:0] ex_mem_fs,
  output logic [1:0] mem_wb_fs
);

  logic         mem_req_raw;
  logic         mem_stall;
  logic         mem_err_raw;
  fetch_state_t fetch_state;
  logic         kill;
  logic         load_use;
  logic         branch;
  logic         front_stall;
  logic         fetch_wait;
  logic         fetch_killed;
  logic         fetch_capture;
  logic         pc_stall_raw;
  logic         pc_redirect_raw;
  fs_t          if_id_raw;
  fs_t          id_ex_raw;
  fs_t          ex_mem_raw;
  fs_t          mem_wb_raw;

  mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_mem_wait (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_access(mem_access),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req_raw),
    .mem_stall (mem_stall),
    .mem_err   (mem_err_raw)
  );

  // Hazard detection and fetch-state decode; a stalled data access suppresses the branch.
  always_comb begin
    load_use      = ex_mem_read && (ex_rd_addr != REG_ZERO) &&
                    (src_match(id_uses_rs1, id_rs1_addr, ex_rd_addr) ||
                     src_match(id_uses_rs2, id_rs2_addr, ex_rd_addr));
    branch        = br_taken && !mem_stall;
    front_stall   = mem_stall || load_use;
    fetch_wait    = (fetch_state == F_BUSY) && !if_ack;
    fetch_killed  = (fetch_state == F_BUSY) && if_ack && kill;
    fetch_capture = (fetch_state == F_BUSY) && if_ack && !kill && !branch && front_stall;
  end

  // Fetch FSM: back-to-back requests, a one-word hold buffer while the front end is
  // stalled, and a kill flag that discards a wrong-path word still in flight at a branch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_state <= F_IDLE;
      kill        <= 1'b0;
    end else begin
      case (fetch_state)
        F_IDLE: fetch_state <= F_BUSY;
        F_BUSY: begin
          if (if_ack) begin
            if (kill) begin
              kill        <= 1'b0;
              fetch_state <= F_IDLE;
            end else if (!branch && front_stall) begin
              fetch_state <= F_HOLD;
            end
          end else if (branch) begin
            kill <= 1'b1;
          end
        end
        F_HOLD: begin
          if (branch || !front_stall) fetch_state <= F_BUSY;
        end
        default: begin
          fetch_state <= F_IDLE;
          kill        <= 1'b0;
        end
      endcase
    end
  end

  // Priority mux per register: data stall, then branch, then load-use, then fetch bubbles.
  always_comb begin
    pc_stall_raw    = 1'b0;
    pc_redirect_raw = 1'b0;
    if_id_raw       = FS_NONE;
    id_ex_raw       = FS_NONE;
    ex_mem_raw      = FS_NONE;
    mem_wb_raw      = FS_NONE;
    if (mem_stall) begin
      pc_stall_raw = 1'b1;
      if_id_raw    = FS_STALL;
      id_ex_raw    = FS_STALL;
      ex_mem_raw   = FS_STALL;
      mem_wb_raw   = FS_FLUSH;
    end else if (branch) begin
      pc_redirect_raw = 1'b1;
      if_id_raw       = FS_FLUSH;
      id_ex_raw       = FS_FLUSH;
      ex_mem_raw      = FS_FLUSH;
    end else if (load_use) begin
      pc_stall_raw = 1'b1;
      if_id_raw    = FS_STALL;
      id_ex_raw    = FS_FLUSH;
    end else if (fetch_wait) begin
      pc_stall_raw = 1'b1;
      if_id_raw    = FS_FLUSH;
    end else if (fetch_killed) begin
      if_id_raw = FS_FLUSH;
    end
  end

  // Output stage: everything is held quiet while reset is asserted.
  always_comb begin
    if_req      = 1'b0;
    mem_req     = 1'b0;
    if_hold     = 1'b0;
    pc_stall    = 1'b0;
    pc_redirect = 1'b0;
    mem_err     = 1'b0;
    if_id_fs    = FS_NONE;
    id_ex_fs    = FS_NONE;
    ex_mem_fs   = FS_NONE;
    mem_wb_fs   = FS_NONE;
    if (reset_n) begin
      if_req      = (fetch_state == F_BUSY);
      mem_req     = mem_req_raw;
      if_hold     = fetch_capture;
      pc_stall    = pc_stall_raw;
      pc_redirect = pc_redirect_raw;
      mem_err     = mem_err_raw;
      if_id_fs    = if_id_raw;
      id_ex_fs    = id_ex_raw;
      ex_mem_fs   = ex_mem_raw;
      mem_wb_fs   = mem_wb_raw;
    end
  end

endmodule
